// File: rtl/range_tracker_pkg.sv
// Shared state encoding and width helpers for range_tracker.
package range_tracker_pkg;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_ACCUM = 1'b1;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int width_for(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/range_tracker_comp.sv
// Unsigned magnitude comparator: exactly one of gt/lt/eq is high for a vs b.
// Purely combinational, no state.
module comp #(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/range_tracker.sv
// Windowed min/max tracker; result registered, Out_valid pulses the cycle after the last sample.
// No backpressure; Clear drops the partial window. RANGE_TRACKER_IDX_EN adds MaxIdx/MinIdx.
module range_tracker
   import range_tracker_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int WINDOW    = 16,
   localparam int CNTWIDTH = width_for(WINDOW + 1),
   localparam int IDXWIDTH = width_for(WINDOW)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 In_valid,
   input  logic [DATAWIDTH-1:0] Din,
   input  logic                 Clear,
   output logic [DATAWIDTH-1:0] Max,
   output logic [DATAWIDTH-1:0] Min,
`ifdef RANGE_TRACKER_IDX_EN
   output logic [IDXWIDTH-1:0]  MaxIdx,
   output logic [IDXWIDTH-1:0]  MinIdx,
`endif
   output logic                 Out_valid
);

   logic                 state;
   logic [CNTWIDTH-1:0]  cnt;
   logic [DATAWIDTH-1:0] acc_max, acc_min;
   logic                 max_gt, max_lt, max_eq;
   logic                 min_gt, min_lt, min_eq;
   logic                 upd_max, upd_min, last;
   logic [DATAWIDTH-1:0] fold_max, fold_min;

   comp #(.DATAWIDTH(DATAWIDTH)) u_comp_max (
      .a(Din), .b(acc_max), .gt(max_gt), .lt(max_lt), .eq(max_eq));
   comp #(.DATAWIDTH(DATAWIDTH)) u_comp_min (
      .a(Din), .b(acc_min), .gt(min_gt), .lt(min_lt), .eq(min_eq));

   // Replace only on a strict win; ties keep the earliest sample.
   assign upd_max  = ({max_gt, max_lt, max_eq} == 3'b100);
   assign upd_min  = ({min_gt, min_lt, min_eq} == 3'b010);
   assign last     = (cnt == CNTWIDTH'(WINDOW - 1));
   assign fold_max = (state == ST_EMPTY || upd_max) ? Din : acc_max;
   assign fold_min = (state == ST_EMPTY || upd_min) ? Din : acc_min;

`ifdef RANGE_TRACKER_IDX_EN
   logic [IDXWIDTH-1:0] acc_max_idx, acc_min_idx, cur_idx, fold_max_idx, fold_min_idx;
   assign cur_idx      = cnt[IDXWIDTH-1:0];
   assign fold_max_idx = (state == ST_EMPTY || upd_max) ? cur_idx : acc_max_idx;
   assign fold_min_idx = (state == ST_EMPTY || upd_min) ? cur_idx : acc_min_idx;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         acc_max_idx <= '0;
         acc_min_idx <= '0;
         MaxIdx      <= '0;
         MinIdx      <= '0;
      end else if (!Clear && In_valid) begin
         if (last) begin
            MaxIdx <= fold_max_idx;
            MinIdx <= fold_min_idx;
         end else begin
            acc_max_idx <= fold_max_idx;
            acc_min_idx <= fold_min_idx;
         end
      end
   end
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= ST_EMPTY;
         cnt       <= '0;
         acc_max   <= '0;
         acc_min   <= '0;
         Max       <= '0;
         Min       <= '0;
         Out_valid <= 1'b0;
      end else begin
         Out_valid <= 1'b0;
         if (Clear) begin
            state <= ST_EMPTY;
            cnt   <= '0;
         end else if (In_valid) begin
            if (last) begin
               Max       <= fold_max;
               Min       <= fold_min;
               Out_valid <= 1'b1;
               cnt       <= '0;
               state     <= ST_EMPTY;
            end else begin
               acc_max <= fold_max;
               acc_min <= fold_min;
               cnt     <= cnt + CNTWIDTH'(1);
               state   <= ST_ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_range_tracker.sv
// Directed and random stimulus for range_tracker (WINDOW=4) against a window-list reference model.
module tb_range_tracker;

   localparam int DW = 8;
   localparam int WIN = 4;

   logic          Clk = 1'b0;
   logic          Rst, In_valid, Clear;
   logic [DW-1:0] Din;
   logic [DW-1:0] Max, Min;
   logic          Out_valid;
`ifdef RANGE_TRACKER_IDX_EN
   logic [1:0]    MaxIdx, MinIdx;
`endif

   range_tracker #(.DATAWIDTH(DW), .WINDOW(WIN)) dut (
      .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .Din(Din), .Clear(Clear),
      .Max(Max), .Min(Min),
`ifdef RANGE_TRACKER_IDX_EN
      .MaxIdx(MaxIdx), .MinIdx(MinIdx),
`endif
      .Out_valid(Out_valid));

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int pulses[$];

   // Reference model: list of samples in the open window plus last published result.
   int win_q[$];
   int m_max = 0, m_min = 0, m_max_idx = 0, m_min_idx = 0;
   logic m_vld = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input logic v, input int d, input logic c, input logic r);
      m_vld = 1'b0;
      if (r) begin
         win_q.delete();
         m_max = 0; m_min = 0; m_max_idx = 0; m_min_idx = 0;
      end else if (c) begin
         win_q.delete();
      end else if (v) begin
         win_q.push_back(d);
         if (win_q.size() == WIN) begin
            m_max = win_q[0]; m_min = win_q[0]; m_max_idx = 0; m_min_idx = 0;
            for (int i = 1; i < WIN; i++) begin
               if (win_q[i] > m_max) begin m_max = win_q[i]; m_max_idx = i; end
               if (win_q[i] < m_min) begin m_min = win_q[i]; m_min_idx = i; end
            end
            m_vld = 1'b1;
            win_q.delete();
         end
      end
   endtask

   task automatic step(input logic v, input int d, input logic c, input logic r);
      In_valid = v; Din = DW'(d); Clear = c; Rst = r;
      @(posedge Clk);
      model(v, d, c, r);
      #1;
      cyc++;
      if (Out_valid === 1'b1) pulses.push_back(cyc);
      chk("out_valid", {31'd0, Out_valid}, {31'd0, m_vld});
      chk("max", {24'd0, Max}, m_max);
      chk("min", {24'd0, Min}, m_min);
`ifdef RANGE_TRACKER_IDX_EN
      chk("max_idx", {30'd0, MaxIdx}, m_max_idx);
      chk("min_idx", {30'd0, MinIdx}, m_min_idx);
`endif
   endtask

   task automatic send4(input int vals[4], input int max_gap);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, vals[i], 1'b0, 1'b0);
         if (max_gap > 0)
            repeat ($urandom_range(max_gap, 0)) step(1'b0, 0, 1'b0, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset, then reset in the middle of a window.
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 33, 1'b0, 1'b0);
      step(1'b1, 44, 1'b0, 1'b0);
      step(1'b1, 55, 1'b1, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      chk("rst_max", {24'd0, Max}, 0);
      chk("rst_min", {24'd0, Min}, 0);
      chk("rst_vld", {31'd0, Out_valid}, 0);
      send4('{8, 90, 2, 60}, 0);
      idle(1);

      // Basic contiguous window; pulse must appear right after the 4th sample.
      pulses.delete();
      send4('{5, 200, 3, 17}, 0);
      chk("basic_pulse_cnt", pulses.size(), 1);
      chk("basic_max", {24'd0, Max}, 200);
      chk("basic_min", {24'd0, Min}, 3);
`ifdef RANGE_TRACKER_IDX_EN
      chk("basic_max_idx", {30'd0, MaxIdx}, 1);
      chk("basic_min_idx", {30'd0, MinIdx}, 2);
`endif
      idle(2);

      // Gapped input.
      for (int k = 0; k < 3; k++) send4('{5, 200, 3, 17}, 3);
      idle(1);

      // Ties and extremes.
      send4('{7, 7, 7, 7}, 0);
      chk("tie_max", {24'd0, Max}, 7);
      send4('{0, 255, 0, 255}, 0);
      chk("ext_max", {24'd0, Max}, 255);
      chk("ext_min", {24'd0, Min}, 0);
      idle(1);

      // Clear with a sample: sample dropped, partial window discarded.
      step(1'b1, 120, 1'b0, 1'b0);
      step(1'b1, 130, 1'b0, 1'b0);
      step(1'b1, 99, 1'b1, 1'b0);
      send4('{9, 1, 250, 4}, 0);
      chk("clr_max", {24'd0, Max}, 250);
      chk("clr_min", {24'd0, Min}, 1);

      // Clear on the completing sample: no pulse, outputs held.
      step(1'b1, 11, 1'b0, 1'b0);
      step(1'b1, 12, 1'b0, 1'b0);
      step(1'b1, 13, 1'b0, 1'b0);
      step(1'b1, 14, 1'b1, 1'b0);
      chk("clr_last_hold", {24'd0, Max}, 250);
      idle(1);

      // Back-to-back windows.
      pulses.delete();
      send4('{10, 20, 30, 40}, 0);
      chk("b2b_max0", {24'd0, Max}, 40);
      chk("b2b_min0", {24'd0, Min}, 10);
      send4('{1, 2, 3, 4}, 0);
      chk("b2b_max1", {24'd0, Max}, 4);
      chk("b2b_min1", {24'd0, Min}, 1);
      chk("b2b_pulse_cnt", pulses.size(), 2);
      if (pulses.size() == 2) chk("b2b_spacing", pulses[1] - pulses[0], 4);
      idle(1);

      // Random traffic with occasional Clear and rare Rst.
      for (int i = 0; i < 600; i++) begin
         logic v, c, r;
         int d;
         v = ($urandom_range(99, 0) < 70);
         c = ($urandom_range(99, 0) < 5);
         r = ($urandom_range(299, 0) == 0);
         d = ($urandom_range(3, 0) == 0) ? ($urandom_range(1, 0) * 255) : $urandom_range(255, 0);
         step(v, d, c, r);
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
